tqvp_htfab_vga_capture: RTL and testbench

//  TinyQV peripheral that receives a 1-bit VGA signal (hsync, vsync, pixel) on ui_in.

---
 rtl/tqvp_htfab_vga_capture.sv | 233 +++++++++++++++++++++++
 tb/tb_tqvp_htfab_vga_capture.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_htfab_vga_capture.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tqvp_htfab_vga_capture                                       |
// | Description : 1-bit VGA capture into a 32x16 framebuffer readable as words |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tqvp_htfab_vga_capture #(
  parameter int unsigned H_BACK       = 176,
  parameter int unsigned X_STEP       = 32,
  parameter int unsigned V_BACK       = 53,
  parameter int unsigned Y_STEP       = 48,
  parameter int unsigned HSYNC_BIT    = 7,
  parameter int unsigned VSYNC_BIT    = 3,
  parameter int unsigned PIX_BIT      = 6,
  parameter bit          SYNC_ACT_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_WAIT_VS = 2'd1;
  localparam logic [1:0] c_ACTIVE  = 2'd2;
  localparam logic [1:0] c_DONE    = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic        w_busy;

  logic        r_hs_q;
  logic        r_vs_q;
  logic        w_hs;
  logic        w_vs;
  logic        w_pix;
  logic        w_hs_end;
  logic        w_hs_start;
  logic        w_vs_end;
  logic        w_vs_start;

  logic [11:0] r_hcnt;
  logic [11:0] r_next_sample;
  logic [5:0]  r_col;
  logic [10:0] r_line;
  logic [10:0] r_next_line;
  logic [3:0]  r_row;
  logic [31:0] r_line_buf;
  logic [31:0] r_fb [16];

  logic        r_done;
  logic        r_err;
  logic        r_irq_en;
  logic [31:0] r_data_out;
  logic        r_data_ready;

  logic        w_wr8;
  logic        w_arm;
  logic        w_clear;
  logic        w_sample;
  logic        w_commit;
  logic        w_last_commit;
  logic        w_abort;
  logic        w_rd_req;
  logic        w_unused;

  assign w_hs       = ui_in[HSYNC_BIT] ^ SYNC_ACT_LOW;
  assign w_vs       = ui_in[VSYNC_BIT] ^ SYNC_ACT_LOW;
  assign w_pix      = ui_in[PIX_BIT];
  assign w_hs_end   = r_hs_q & ~w_hs;
  assign w_hs_start = ~r_hs_q & w_hs;
  assign w_vs_end   = r_vs_q & ~w_vs;
  assign w_vs_start = ~r_vs_q & w_vs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs_q <= 1'b0;
      r_vs_q <= 1'b0;
    end else begin
      r_hs_q <= w_hs;
      r_vs_q <= w_vs;
    end
  end

  // Only 8-bit writes reach the control register; arm outranks clear.
  assign w_wr8   = (data_write_n == 2'b00);
  assign w_arm   = w_wr8 & data_in[0];
  assign w_clear = w_wr8 & data_in[2] & ~data_in[0];

  // Sampling uses a running target so no multiplier is needed.
  assign w_sample      = (r_state == c_ACTIVE) && (r_hcnt == r_next_sample) && !r_col[5];
  assign w_commit      = (r_state == c_ACTIVE) && !w_arm && w_hs_start && (r_line == r_next_line);
  assign w_last_commit = w_commit && (r_row == 4'd15);
  assign w_abort       = (r_state == c_ACTIVE) && !w_arm && w_vs_start && !w_last_commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_arm) w_state_next = c_WAIT_VS;
      end
      c_WAIT_VS: begin
        if (w_arm)         w_state_next = c_WAIT_VS;
        else if (w_vs_end) w_state_next = c_ACTIVE;
      end
      c_ACTIVE: begin
        if (w_arm)              w_state_next = c_WAIT_VS;
        else if (w_last_commit) w_state_next = c_DONE;
        else if (w_abort)       w_state_next = c_WAIT_VS;
      end
      c_DONE: begin
        if (w_arm) w_state_next = c_WAIT_VS;
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == c_WAIT_VS) || (r_state == c_ACTIVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt        <= '0;
      r_next_sample <= '0;
      r_col         <= '0;
      r_line        <= '0;
      r_next_line   <= '0;
      r_row         <= '0;
      r_line_buf    <= '0;
    end else if (w_arm) begin
      r_row <= '0;
    end else if (r_state == c_WAIT_VS) begin
      if (w_vs_end) begin
        r_line      <= '0;
        r_next_line <= 11'(V_BACK);
        r_row       <= '0;
      end
    end else if (r_state == c_ACTIVE) begin
      if (w_hs_end) begin
        r_hcnt        <= '0;
        r_col         <= '0;
        r_next_sample <= 12'(H_BACK);
        r_line_buf    <= '0;
        if (r_line != '1) r_line <= r_line + 11'd1;
      end else begin
        if (r_hcnt != '1) r_hcnt <= r_hcnt + 12'd1;
        if (w_sample) begin
          r_line_buf[r_col[4:0]] <= w_pix;
          r_col                  <= r_col + 6'd1;
          r_next_sample          <= r_next_sample + 12'(X_STEP);
        end
      end
      if (w_commit) begin
        r_row       <= r_row + 4'd1;
        r_next_line <= r_next_line + 11'(Y_STEP);
      end
    end
  end

  // Columns never sampled on a short line are still zero from the hs_end clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_fb[i] <= '0;
    end else if (w_commit) begin
      r_fb[r_row] <= r_line_buf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      if (w_wr8) r_irq_en <= data_in[1];
      if (w_arm) begin
        r_done <= 1'b0;
      end else if (w_clear) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end else if (w_last_commit) begin
        r_done <= 1'b1;
      end else if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  // A request seen while the previous acknowledge is high is dropped.
  assign w_rd_req = (data_read_n != 2'b11) && !r_data_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out   <= '0;
      r_data_ready <= 1'b0;
    end else begin
      r_data_ready <= w_rd_req;
      if (w_rd_req) begin
        case (data_read_n)
          2'b10:   r_data_out <= r_fb[address[5:2]];
          2'b00:   r_data_out <= {29'b0, r_err, r_done, w_busy};
          default: r_data_out <= '0;
        endcase
      end
    end
  end

  assign data_out       = r_data_out;
  assign data_ready     = r_data_ready;
  assign user_interrupt = r_done & r_irq_en;
  assign uo_out         = 8'h00;

  assign w_unused = &{1'b0, address[1:0], data_in[31:3], ui_in};

endmodule
`default_nettype wire

// File: tb/tb_tqvp_htfab_vga_capture.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tqvp_htfab_vga_capture                                    |
// | Description : scoreboard bench driving a scaled-down VGA frame generator   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tqvp_htfab_vga_capture;

  localparam int c_HS    = 4;
  localparam int c_HBP   = 8;
  localparam int c_XS    = 4;
  localparam int c_VIS0  = c_HS + c_HBP;
  localparam int c_LINE  = c_VIS0 + 32 * c_XS + 4;
  localparam int c_VS    = 2;
  localparam int c_VBP   = 2;
  localparam int c_YS    = 2;
  localparam int c_FRAME = c_VS + c_VBP + 16 * c_YS + 2;

  logic        clk;
  logic        rst;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  tqvp_htfab_vga_capture #(
    .H_BACK(c_HBP + 2), .X_STEP(c_XS), .V_BACK(c_VBP + 2), .Y_STEP(c_YS),
    .HSYNC_BIT(7), .VSYNC_BIT(3), .PIX_BIT(6), .SYNC_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass   = 0;
  int          n_checks = 0;
  int          rd_idx   = 0;
  logic [31:0] exp_q [$];

  logic [31:0] m_fb    [16];
  logic [31:0] gen_pat [16];
  bit          m_busy, m_done, m_err, m_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (data_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ready: data_ready=1 with no outstanding read");
      end else begin
        rd_idx++;
        chk($sformatf("read%0d", rd_idx), data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Sync pins are active-low; unused pins carry noise.
  function automatic logic [7:0] pins(input bit hs_act, input bit vs_act, input bit px);
    logic [7:0] v;
    v    = 8'($urandom);
    v[7] = ~hs_act;
    v[3] = ~vs_act;
    v[6] = px;
    return v;
  endfunction

  function automatic logic [31:0] m_status();
    return {29'b0, m_err, m_done, m_busy};
  endfunction

  task automatic drive_line(input bit vs_act, input logic [31:0] pix, input int len);
    bit px;
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      px = (k >= c_VIS0 && k < c_VIS0 + 32 * c_XS) ? pix[(k - c_VIS0) / c_XS] : 1'b0;
      ui_in = pins(k < c_HS, vs_act, px);
    end
  endtask

  task automatic drive_frame(input int n_lines, input int len);
    logic [31:0] pix;
    for (int j = 0; j < n_lines; j++) begin
      if (j >= c_VS + c_VBP && j < c_VS + c_VBP + 16 * c_YS) pix = gen_pat[(j - c_VS - c_VBP) / c_YS];
      else pix = '0;
      drive_line(j < c_VS, pix, len);
    end
  endtask

  task automatic hold_vs(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ui_in = pins(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic bus_write(input logic [1:0] sz, input logic [31:0] d);
    @(posedge clk); #1;
    data_write_n = sz;
    data_in      = d;
    @(posedge clk); #1;
    data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [1:0] sz, input logic [5:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    data_read_n = sz;
    address     = a;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    data_read_n = 2'b11;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic arm(input bit irq);
    bus_write(2'b00, {30'b0, irq, 1'b1});
    m_irq  = irq;
    m_busy = 1'b1;
    m_done = 1'b0;
  endtask

  task automatic apply_full(input logic [31:0] mask);
    for (int r = 0; r < 16; r++) m_fb[r] = gen_pat[r] & mask;
    m_done = 1'b1;
    m_busy = 1'b0;
  endtask

  task automatic check_rows();
    for (int r = 0; r < 16; r++) bus_read(2'b10, 6'(r * 4), m_fb[r]);
  endtask

  task automatic random_pattern();
    for (int r = 0; r < 16; r++) gen_pat[r] = $urandom;
  endtask

  initial begin
    bit irqr;
    rst          = 1'b1;
    ui_in        = pins(1'b0, 1'b0, 1'b0);
    address      = '0;
    data_in      = '0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    {m_busy, m_done, m_err, m_irq} = '0;
    for (int r = 0; r < 16; r++) m_fb[r] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_data_ready", 32'(data_ready), 32'h0);
    chk("rst_irq", 32'(user_interrupt), 32'h0);
    chk("rst_uo_out", 32'(uo_out), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    bus_read(2'b00, 6'd0, m_status());
    bus_read(2'b10, 6'd0, 32'h0);
    bus_read(2'b10, 6'd60, 32'h0);

    // 16-bit write must not arm
    bus_write(2'b01, 32'h7);
    bus_read(2'b00, 6'd0, m_status());

    // alternating column pattern with interrupt enabled
    arm(1'b1);
    bus_read(2'b00, 6'd0, m_status());
    for (int r = 0; r < 16; r++) gen_pat[r] = 32'hAAAAAAAA;
    drive_frame(c_FRAME, c_LINE);
    apply_full('1);
    bus_read(2'b00, 6'd0, m_status());
    bus_read(2'b01, 6'd4, 32'h0);
    chk("irq_done", 32'(user_interrupt), 32'(m_done & m_irq));
    check_rows();
    bus_write(2'b00, 32'h6);
    m_done = 1'b0;
    m_err  = 1'b0;
    #1 chk("irq_cleared", 32'(user_interrupt), 32'h0);
    bus_read(2'b00, 6'd0, m_status());

    // row-index pattern, interrupt disabled
    arm(1'b0);
    for (int r = 0; r < 16; r++) gen_pat[r] = r * 32'h01010101;
    drive_frame(c_FRAME, c_LINE);
    apply_full('1);
    bus_read(2'b00, 6'd0, m_status());
    chk("irq_masked", 32'(user_interrupt), 32'h0);
    check_rows();

    // random image, random irq enable
    irqr = 1'($urandom_range(0, 1));
    arm(irqr);
    random_pattern();
    drive_frame(c_FRAME, c_LINE);
    apply_full('1);
    chk("irq_random", 32'(user_interrupt), 32'(m_irq));
    check_rows();

    // vsync after 5 committed rows, then a clean retry frame
    arm(1'b0);
    random_pattern();
    drive_frame(c_VS + c_VBP + 5 * c_YS + 1, c_LINE);
    hold_vs(8);
    m_err = 1'b1;
    for (int r = 0; r < 5; r++) m_fb[r] = gen_pat[r];
    bus_read(2'b00, 6'd0, m_status());
    check_rows();
    random_pattern();
    drive_frame(c_FRAME, c_LINE);
    apply_full('1);
    bus_read(2'b00, 6'd0, m_status());
    check_rows();
    bus_write(2'b00, 32'h4);
    m_err  = 1'b0;
    m_done = 1'b0;
    bus_read(2'b00, 6'd0, m_status());

    // lines cut short after 10 samples
    arm(1'b0);
    for (int r = 0; r < 16; r++) gen_pat[r] = 32'hFFFFFFFF;
    drive_frame(c_FRAME, c_VIS0 + 10 * c_XS);
    apply_full(32'h000003FF);
    bus_read(2'b00, 6'd0, m_status());
    check_rows();

    // reset in the middle of an active capture
    arm(1'b1);
    bus_read(2'b10, 6'd0, m_fb[0]);
    drive_frame(10, c_LINE);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("midrst_data_out", data_out, 32'h0);
    chk("midrst_data_ready", 32'(data_ready), 32'h0);
    chk("midrst_irq", 32'(user_interrupt), 32'h0);
    chk("midrst_uo_out", 32'(uo_out), 32'h0);
    {m_busy, m_done, m_err, m_irq} = '0;
    for (int r = 0; r < 16; r++) m_fb[r] = '0;
    @(posedge clk); #1 rst = 1'b0;
    bus_read(2'b00, 6'd0, m_status());
    bus_read(2'b10, 6'd0, 32'h0);
    bus_read(2'b10, 6'd4, 32'h0);
    drive_frame(c_FRAME, c_LINE);
    bus_read(2'b00, 6'd0, m_status());
    bus_read(2'b10, 6'd20, 32'h0);

    repeat (4) @(posedge clk);
    chk("reads_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
